// File: rtl/timestamp_capture.sv
// Event timestamp capture: synchronizes an async event line, tags each rising
// edge with {epoch, count} and queues it in a first-word-fall-through FIFO.
module timestamp_capture #(
    parameter int DEPTH   = 4,
    parameter int EPOCH_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           count,
    input  logic                 event_in,
    input  logic                 ts_ready,
    input  logic                 clear_ovf,
    output logic [EPOCH_W+7:0]   ts_data,
    output logic                 ts_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic               sync1, sync2, sync3;
    logic [7:0]         prev_count;
    logic [EPOCH_W-1:0] epoch, epoch_next;
    logic [EPOCH_W+7:0] mem [DEPTH];
    logic [AW-1:0]      wptr, rptr;
    logic               wrap, push, pop, full, accept, drop;

    assign wrap       = (prev_count == 8'hFF) && (count == 8'h00);
    assign epoch_next = epoch + EPOCH_W'(wrap);
    assign push       = sync2 & ~sync3;
    assign ts_valid   = (level != '0);
    assign full       = (level == LW'(DEPTH));
    assign pop        = ts_valid & ts_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign accept     = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign ts_data    = ts_valid ? mem[rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            prev_count <= 8'h00;
            epoch      <= '0;
        end else begin
            sync1      <= event_in;
            sync2      <= sync1;
            sync3      <= sync2;
            prev_count <= count;
            epoch      <= epoch_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wptr] <= {epoch_next, count};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (accept) wptr <= wptr + AW'(1);
            if (pop)    rptr <= rptr + AW'(1);
            unique case ({accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear survives as the first new drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else if (clear_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? 8'h01 : 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
        end
    end

endmodule
